// File: rtl/sys_array_os_if.sv
// Handshake and operand bundle for the output-stationary systolic array.
// The master side feeds operands and consumes results; the slave side is the array.
interface sys_array_os_if #(
    parameter int DATA_W     = 16,
    parameter int ARRAY_SIZE = 2,
    parameter int ACC_W      = 36
);
    logic                           start;
    logic [3:0]                     k_len;
    logic [ARRAY_SIZE*DATA_W-1:0]   data_in;
    logic [ARRAY_SIZE-1:0]          data_valid;
    logic [ARRAY_SIZE*DATA_W-1:0]   weight_in;
    logic [ARRAY_SIZE-1:0]          weight_valid;
    logic                           compute_en;
    logic                           busy;
    logic [ACC_W-1:0]               out_data;
    logic [7:0]                     out_idx;
    logic                           out_valid;
    logic                           out_ready;
    logic                           done;

    modport master (
        output start, k_len, data_in, data_valid, weight_in, weight_valid, out_ready,
        input  compute_en, busy, out_data, out_idx, out_valid, done
    );

    modport slave (
        input  start, k_len, data_in, data_valid, weight_in, weight_valid, out_ready,
        output compute_en, busy, out_data, out_idx, out_valid, done
    );
endinterface

// File: rtl/sys_array_os.sv
// Output-stationary N x N systolic array. Row operands flow right, column operands
// flow down, each PE keeps its own accumulator; results are drained row-major.
module sys_array_os #(
    parameter int DATA_W     = 16,
    parameter int ARRAY_SIZE = 2,
    parameter int ACC_W      = 36
) (
    input logic           clk,
    input logic           rst,
    sys_array_os_if.slave bus
);
    localparam int N = ARRAY_SIZE;

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic [3:0]                 k_reg;
    logic signed [DATA_W-1:0]   a_reg  [N][N];
    logic signed [DATA_W-1:0]   b_reg  [N][N];
    logic                       a_v    [N][N];
    logic                       b_v    [N][N];
    logic signed [DATA_W-1:0]   a_in   [N][N];
    logic signed [DATA_W-1:0]   b_in   [N][N];
    logic                       a_vin  [N][N];
    logic                       b_vin  [N][N];
    logic                       fire   [N][N];
    logic signed [2*DATA_W-1:0] prod   [N][N];
    logic [ACC_W-1:0]           acc    [N][N];
    logic [3:0]                 mac_cnt[N][N];
    logic [3:0]                 row_idx, col_idx;
    logic [ACC_W-1:0]           sel_acc;
    logic                       in_compute, last_mac, last_out, handshake;

    assign in_compute = (state == COMPUTE);
    assign handshake  = (state == DRAIN) && bus.out_ready;
    assign last_out   = (row_idx == 4'(N-1)) && (col_idx == 4'(N-1));
    assign last_mac   = fire[N-1][N-1] &&
                        (({1'b0, mac_cnt[N-1][N-1]} + 5'd1) == {1'b0, k_reg});

    // Operand routing: edge PEs take the external lanes, inner PEs take their neighbour's registers.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_left_edge
                assign a_in[i][j]  = bus.data_in[i*DATA_W +: DATA_W];
                assign a_vin[i][j] = bus.data_valid[i];
            end else begin : g_left_chain
                assign a_in[i][j]  = a_reg[i][j-1];
                assign a_vin[i][j] = a_v[i][j-1];
            end
            if (i == 0) begin : g_top_edge
                assign b_in[i][j]  = bus.weight_in[j*DATA_W +: DATA_W];
                assign b_vin[i][j] = bus.weight_valid[j];
            end else begin : g_top_chain
                assign b_in[i][j]  = b_reg[i-1][j];
                assign b_vin[i][j] = b_v[i-1][j];
            end
            assign fire[i][j] = in_compute && a_vin[i][j] && b_vin[i][j];
            assign prod[i][j] = a_in[i][j] * b_in[i][j];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; a zero-length tile skips straight to draining the cleared accumulators.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = (bus.k_len == 4'd0) ? DRAIN : COMPUTE;
            COMPUTE: if (last_mac) next_state = DRAIN;
            DRAIN:   if (handshake && last_out) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // PE array: forwarding registers run every cycle, accumulators only MAC during COMPUTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j]   <= '0;
                    b_reg[i][j]   <= '0;
                    a_v[i][j]     <= 1'b0;
                    b_v[i][j]     <= 1'b0;
                    acc[i][j]     <= '0;
                    mac_cnt[i][j] <= '0;
                end
            end
        end else begin
            if (state == IDLE && bus.start) k_reg <= bus.k_len;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                    a_v[i][j]   <= a_vin[i][j] && in_compute;
                    b_v[i][j]   <= b_vin[i][j] && in_compute;
                    if (state == IDLE && bus.start) begin
                        acc[i][j]     <= '0;
                        mac_cnt[i][j] <= '0;
                    end else if (fire[i][j]) begin
                        acc[i][j]     <= acc[i][j] +
                                         {{(ACC_W-2*DATA_W){prod[i][j][2*DATA_W-1]}}, prod[i][j]};
                        mac_cnt[i][j] <= mac_cnt[i][j] + 4'd1;
                    end
                end
            end
        end
    end

    // Drain position: restarts at (0,0) on each accepted start and steps row-major per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (state == IDLE && bus.start) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (handshake && !last_out) begin
            if (col_idx == 4'(N-1)) begin
                col_idx <= '0;
                row_idx <= row_idx + 4'd1;
            end else begin
                col_idx <= col_idx + 4'd1;
            end
        end
    end

    // Result select for the current drain position.
    always_comb begin
        sel_acc = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (row_idx == 4'(i) && col_idx == 4'(j)) sel_acc = acc[i][j];
            end
        end
    end

    assign bus.out_data   = (state == DRAIN) ? sel_acc : '0;
    assign bus.out_idx    = {row_idx, col_idx};
    assign bus.out_valid  = (state == DRAIN);
    assign bus.done       = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.compute_en = in_compute;
endmodule

// File: tb/tb_sys_array_os.sv
// Scoreboard bench for sys_array_os: directed tiles push expected results, a monitor
// pops and compares on every handshake.
module tb_sys_array_os;
    localparam int DATA_W = 16;
    localparam int N      = 2;
    localparam int ACC_W  = 36;

    typedef struct {
        logic [7:0]              idx;
        logic signed [ACC_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sys_array_os_if #(.DATA_W(DATA_W), .ARRAY_SIZE(N), .ACC_W(ACC_W)) bus();

    sys_array_os #(.DATA_W(DATA_W), .ARRAY_SIZE(N), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t                     sb[$];
    int                       n_checks   = 0;
    int                       n_fail     = 0;
    int                       done_seen  = 0;
    int                       tiles_done = 0;
    logic signed [DATA_W-1:0] mat_a [N][16];
    logic signed [DATA_W-1:0] mat_b [16][N];
    logic signed [ACC_W-1:0]  exp_c [N*N];
    logic                     stall_mode = 1'b0;
    logic [3:0]               ready_seq  = 4'b1001;
    int                       ready_cnt  = 0;
    logic                     hold_pending = 1'b0;
    logic [ACC_W-1:0]         held_data;
    logic [7:0]               held_idx;
    logic                     prev_done = 1'b0;

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Present the skewed operands for COMPUTE cycle c of a K-long tile.
    task automatic driveLanes(input int c, input int k);
        int kk;
        for (int i = 0; i < N; i++) begin
            kk = c - i;
            if (kk >= 0 && kk < k) begin
                bus.data_in[i*DATA_W +: DATA_W]   = mat_a[i][kk];
                bus.data_valid[i]                 = 1'b1;
                bus.weight_in[i*DATA_W +: DATA_W] = mat_b[kk][i];
                bus.weight_valid[i]               = 1'b1;
            end else begin
                bus.data_in[i*DATA_W +: DATA_W]   = '0;
                bus.data_valid[i]                 = 1'b0;
                bus.weight_in[i*DATA_W +: DATA_W] = '0;
                bus.weight_valid[i]               = 1'b0;
            end
        end
    endtask

    task automatic clearLanes();
        bus.data_in      = '0;
        bus.data_valid   = '0;
        bus.weight_in    = '0;
        bus.weight_valid = '0;
    endtask

    // Run one tile: queue expectations, pulse start, feed skewed lanes, optionally
    // retry start mid-tile or abort with reset, then wait (bounded) for the tile to end.
    task automatic applyStimulus(input int k, input bit stall, input bit mid_start, input bit abort);
        exp_t item;
        stall_mode = stall;
        if (!abort) begin
            for (int e = 0; e < N*N; e++) begin
                item.idx  = {4'(e / N), 4'(e % N)};
                item.data = exp_c[e];
                sb.push_back(item);
            end
        end
        bus.start = 1'b1;
        bus.k_len = 4'(k);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (k > 0) begin
            for (int c = 0; c <= k + 2*N - 3; c++) begin
                driveLanes(c, k);
                bus.start = mid_start && (c == 1);
                if (mid_start && c == 1) bus.k_len = 4'd5;
                if (abort && c == 1) rst = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                if (abort && c == 1) begin
                    rst = 1'b0;
                    clearLanes();
                    checkOutput("abort_out_valid", bus.out_valid, 0);
                    checkOutput("abort_busy", bus.busy, 0);
                    checkOutput("abort_compute_en", bus.compute_en, 0);
                    checkOutput("abort_done", bus.done, 0);
                    checkOutput("abort_out_data", bus.out_data, 0);
                    checkOutput("abort_out_idx", bus.out_idx, 0);
                    stall_mode = 1'b0;
                    return;
                end
            end
        end
        clearLanes();
        for (int t = 0; t < 100 && bus.busy; t++) begin
            @(posedge clk); #1;
        end
        checkOutput("tile_complete_busy", bus.busy, 0);
        tiles_done++;
        checkOutput("done_count", done_seen, tiles_done);
        checkOutput("scoreboard_drained", sb.size(), 0);
        stall_mode = 1'b0;
    endtask

    task automatic loadBasicTile();
        mat_a[0][0] = 16'sd1; mat_a[0][1] = 16'sd2;
        mat_a[1][0] = 16'sd3; mat_a[1][1] = 16'sd4;
        mat_b[0][0] = 16'sd5; mat_b[0][1] = 16'sd6;
        mat_b[1][0] = 16'sd7; mat_b[1][1] = 16'sd8;
        exp_c[0] = 36'sd19; exp_c[1] = 36'sd22; exp_c[2] = 36'sd43; exp_c[3] = 36'sd50;
    endtask

    // Consumer back-pressure: always ready, or the repeating 1,0,0,1 pattern when stalling.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode) begin
                bus.out_ready = ready_seq[ready_cnt % 4];
                ready_cnt++;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: on the falling edge, score handshakes, check stall stability and done behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_pending = 1'b0;
            prev_done    = 1'b0;
        end else begin
            if (bus.done) begin
                checkOutput("done_single_cycle", prev_done, 0);
                checkOutput("done_after_last_result", sb.size(), 0);
                done_seen++;
            end
            if (hold_pending && bus.out_valid) begin
                checkOutput("stall_hold_data", bus.out_data, held_data);
                checkOutput("stall_hold_idx", bus.out_idx, held_idx);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", bus.out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", $signed(bus.out_data), e.data);
                    checkOutput("out_idx", bus.out_idx, e.idx);
                end
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            held_data    = bus.out_data;
            held_idx     = bus.out_idx;
            prev_done    = bus.done;
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        clearLanes();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_compute_en", bus.compute_en, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_out_idx", bus.out_idx, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic 2x2 tile, K=2");
        loadBasicTile();
        applyStimulus(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] basic tile with consumer stalls");
        applyStimulus(2, 1'b1, 1'b0, 1'b0);

        $display("[TB] K=0 tile");
        for (int e = 0; e < N*N; e++) exp_c[e] = '0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] most-negative operands, K=1");
        for (int i = 0; i < N; i++) begin
            mat_a[i][0] = 16'sh8000;
            mat_b[0][i] = 16'sh8000;
        end
        for (int e = 0; e < N*N; e++) exp_c[e] = 36'sd1073741824;
        applyStimulus(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] -1 x 3 sign extension, K=1");
        for (int i = 0; i < N; i++) begin
            mat_a[i][0] = -16'sd1;
            mat_b[0][i] = 16'sd3;
        end
        for (int e = 0; e < N*N; e++) exp_c[e] = -36'sd3;
        applyStimulus(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] stray valids in IDLE, then K=3 tile with ignored second start");
        bus.data_in      = {16'sd100, 16'sd100};
        bus.weight_in    = {16'sd77, 16'sd77};
        bus.data_valid   = '1;
        bus.weight_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        mat_a[0][0] = 16'sd2;  mat_a[0][1] = -16'sd3; mat_a[0][2] = 16'sd1;
        mat_a[1][0] = 16'sd0;  mat_a[1][1] = 16'sd7;  mat_a[1][2] = -16'sd2;
        mat_b[0][0] = 16'sd4;  mat_b[0][1] = 16'sd1;
        mat_b[1][0] = -16'sd5; mat_b[1][1] = 16'sd6;
        mat_b[2][0] = 16'sd3;  mat_b[2][1] = -16'sd1;
        exp_c[0] = 36'sd26; exp_c[1] = -36'sd17; exp_c[2] = -36'sd41; exp_c[3] = 36'sd44;
        applyStimulus(3, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during COMPUTE, then a clean tile");
        loadBasicTile();
        applyStimulus(2, 1'b0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post_abort_busy", bus.busy, 0);
        applyStimulus(2, 1'b0, 1'b0, 1'b0);

        checkOutput("final_scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sys_array_os.md
SYS_ARRAY_OS -- requirements
Module: sys_array_os

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width (signed two's complement).
REQ-002 SHALL have parameter ARRAY_SIZE, default 2, the array dimension N (N x N PEs).
REQ-003 SHALL have parameter ACC_W, default 36, accumulator width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port start, input, 1, one-cycle pulse beginning a tile.
REQ-007 SHALL have port k_len, input, 4, reduction length K, sampled on accepted start.
REQ-008 SHALL have port data_in, input, N*DATA_W, row operands; lane i = bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port data_valid, input, N, per-row-lane valid.
REQ-010 SHALL have port weight_in, input, N*DATA_W, column operands; lane j as for data_in.
REQ-011 SHALL have port weight_valid, input, N, per-column-lane valid.
REQ-012 SHALL have port compute_en, output, 1, high in COMPUTE; drives the upstream queue's compute start.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 SHALL have port out_data, output, ACC_W, result word being drained.
REQ-015 SHALL have port out_idx, output, 2*4, {row, col} of out_data, 4 bits each.
REQ-016 SHALL have port out_valid, output, 1, out_data valid.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts when out_valid && out_ready.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after the last result is accepted.

Function
REQ-019 SHALL implement output-stationary PEs: PE(i,j) left operand = data_in lane i when j=0, otherwise PE(i,j-1)'s registered left operand/valid; top operand = weight_in lane j when i=0, otherwise PE(i-1,j)'s registered top operand/valid.
REQ-020 In COMPUTE, PE(i,j) SHALL do acc <= acc + sext(a*b) on an edge only when both incoming valids are high, and SHALL count that MAC.
REQ-021 Product SHALL be full 2*DATA_W signed, sign-extended to ACC_W; overflow SHALL wrap modulo 2^ACC_W.
REQ-022 Operand and valid forwarding registers SHALL update every cycle in every state, but valids SHALL be forced to 0 outside COMPUTE.
REQ-023 FSM states SHALL be IDLE, COMPUTE, DRAIN, DONE.
REQ-024 IDLE -> COMPUTE on start: all accumulators and MAC counters cleared on that edge, k_len latched.
REQ-025 When the latched K = 0, start SHALL go IDLE -> DRAIN directly with cleared accumulators.
REQ-026 COMPUTE -> DRAIN on the edge where PE(N-1,N-1)'s MAC count reaches K.
REQ-027 DRAIN SHALL present results row-major (0,0),(0,1),...,(N-1,N-1), with out_valid high, and SHALL advance on each out_valid && out_ready.
REQ-028 While out_valid && !out_ready, out_data and out_idx SHALL hold stable.
REQ-029 After the N*N-th handshake, the FSM SHALL go DRAIN -> DONE; DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-030 start SHALL be ignored when not in IDLE.
REQ-031 Valid lanes asserted in IDLE, DRAIN or DONE SHALL cause no MAC.
REQ-032 Upstream SHALL skew lanes: row lane i carries A[i][k] at COMPUTE cycle k+i; column lane j carries B[k][j] at cycle k+j. PE(i,j) then pairs the k-th terms at cycle k+i+j.

Reset
REQ-033 On rst, state SHALL become IDLE, and all accumulators, counters, forwarding registers, out_data, out_idx, out_valid, done, compute_en and busy SHALL be 0.
REQ-034 rst asserted mid-COMPUTE or mid-DRAIN SHALL abort the tile with no further out_valid or done.

Verification
REQ-035 N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], skewed feed, out_ready=1 -> outputs 19,22,43,50 with idx 00,01,10,11 on consecutive cycles, then done pulse, busy=0.
REQ-036 Same tile with out_ready toggled 1,0,0,1,... -> identical sequence; out_data held during stalls; exactly 4 handshakes.
REQ-037 K=0 start -> four outputs of 0, then done.
REQ-038 A=-32768 x B=-32768, K=1 on all PEs -> 1073741824 on each result; A=-1, B=3 -> -3 sign-extended to 36 bits.
REQ-039 Second start during COMPUTE ignored; stray valids in IDLE -> next tile results unaffected.
REQ-040 rst pulsed at COMPUTE cycle 1 -> all outputs 0, state IDLE; a following clean tile produces the REQ-035 results.
